sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
Upstream stage of the SHA-256 compression engine. Reads a message of num_words 32-bit words from the shared single-port word memory and appends SHA-256 padding: the 0x80000000 marker, zero fill, and the 64-bit bit-length. It emits the padded message as a valid/ready stream of 32-bit words, grouped in 16-word blocks, to the compression core. It never writes memory.

Parameters:
MAX_WORDS, 64, maximum accepted num_words; sizes internal counters.
FIFO_DEPTH, 2, output buffer depth in words; fixed at 2 so full throughput survives the 1-cycle memory read latency.

Ports:
clk  in  1  clock; mem_clk is driven from it
reset_n  in  1  synchronous active-low reset
start  in  1  level; sampled only in IDLE
message_addr  in  16  word address of the first message word; latched at start
num_words  in  16  message length in words, 1..MAX_WORDS; latched at start
busy  out  1  high from the start-accept cycle until done
done  out  1  one-cycle pulse after the final word is accepted
mem_clk  out  1  equals clk
mem_we  out  1  constant 0
mem_addr  out  16  read address
mem_write_data  out  32  constant 0
mem_read_data  in  32  read data, valid the cycle after the address is presented
out_valid  out  1  stream valid
out_ready  in  1  stream ready from the compression core
out_data  out  32  padded word
out_word_idx  out  4  word index within the current block, 0..15
out_block_last  out  1  high on word 15 of the final block

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE and the FIFO is flushed.
  - busy, done, out_valid, out_block_last, out_word_idx, mem_addr and out_data all go to 0.
  - Reset mid-stream abandons the message; no further words are emitted.
- Total padded length:
  - T = 16*ceil((N+3)/16) words, where N = latched num_words.
  - Examples: N=13 gives T=16; N=14 gives T=32; N=20 gives T=32.
- Word i of the padded stream:
  - i<N: mem[message_addr+i].
  - i=N: 0x80000000.
  - N<i<T-2: 0.
  - i=T-2: bit-length[63:32], which is always 0 for a 16-bit N.
  - i=T-1: bit-length[31:0] = {N[26:0],5'b0} = 32*N.
- A start with N=0 or N>MAX_WORDS is ignored: the block stays in IDLE, busy stays 0 and done is not pulsed.
- FSM states:
  - IDLE: on start with legal N, latch message_addr and N, clear the counters, set busy, go to READ.
  - READ:
    - Present mem_addr = message_addr + rd_cnt and increment rd_cnt when the FIFO has a free slot, counting the read in flight.
    - The data returned the next cycle is pushed into the FIFO.
    - After read N-1 is issued, go to PAD.
  - PAD:
    - Generated words for i = N..T-1 are pushed whenever the FIFO has space.
    - A generated word never overtakes an in-flight memory word.
    - After word T-1 is pushed, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and the final word has been accepted, then go to FINISH.
  - FINISH: pulse done for 1 cycle, clear busy, return to IDLE.
- Handshake:
  - A word transfers when out_valid and out_ready are both high at a clk edge.
  - While out_valid=1 and out_ready=0, out_data, out_word_idx and out_block_last hold stable.
  - out_valid is never withdrawn without a transfer.
- out_word_idx: 4-bit counter of accepted words; it wraps 15→0 at each block boundary.
- Throughput: with out_ready held high, one word per cycle after a 2-cycle fill latency, so the first out_valid appears 2 cycles after start is accepted.
- Address arithmetic: 16-bit, wraps modulo 2^16.
- start while busy is ignored.
- done and a new start in the same cycle: the new start is not sampled until the next cycle in IDLE.

Decomposition:
- Shared package sha256_pkg:
  - SHA256_BLOCK_WORDS=16
  - SHA256_PAD_MARKER=32'h80000000
  - padder state enum
  - function pad_total_words(N)
- One sub-module, sha256_word_fifo: 2-entry synchronous FIFO, 32-bit data plus 1 tag bit, with full, empty, push and pop signals. It absorbs the read latency under backpressure.

Test Plan:
1. N=20, message_addr=0, words seeded 0x01234765 then rotate-left-1 per word, word 19=0, out_ready=1 → 32 words in order. Word 20 is 0x80000000, words 21..30 are 0, word 31 is 0x00000280. out_block_last is high only on word 31, and done pulses once.
2. N=13 → 16 words. Word 13 is 0x80000000, word 14 is 0, word 15 is 0x000001A0 with out_block_last=1 and out_word_idx=15.
3. N=14 → 32 words. Word 14 is 0x80000000, words 15..29 are 0, word 31 is 0x000001C0. out_word_idx wraps 15→0 after word 15.
4. N=20 with out_ready driven by a random 50% pattern → the transferred sequence is identical to scenario 1, with no drops or duplicates. Outputs hold stable while stalled, and mem_we stays 0 throughout.
5. reset_n=0 for 1 cycle after 5 words of an N=20 run → all outputs go to 0 next cycle. A fresh start with N=13 then produces a correct 16-word stream.
6. start pulsed while busy, and start with N=0 → both ignored. The current stream is unaffected, and no extra done pulse occurs.

Source files
------------

// File: rtl/sha256_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sha256_pkg : shared SHA-256 constants, padder state encoding, length math  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package sha256_pkg;

  localparam int          SHA256_BLOCK_WORDS = 16;
  localparam logic [31:0] SHA256_PAD_MARKER  = 32'h8000_0000;

  typedef logic [2:0] padder_state_t;

  localparam padder_state_t c_st_idle   = 3'd0;
  localparam padder_state_t c_st_read   = 3'd1;
  localparam padder_state_t c_st_pad    = 3'd2;
  localparam padder_state_t c_st_drain  = 3'd3;
  localparam padder_state_t c_st_finish = 3'd4;

  // Room for the marker plus the two length words, rounded up to a whole block.
  function automatic logic [15:0] pad_total_words(input logic [15:0] n);
    logic [15:0] t;
    t = n + 16'(SHA256_BLOCK_WORDS + 2);
    return t & ~16'(SHA256_BLOCK_WORDS - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sha256_word_fifo : small synchronous FIFO for padded words (data + tag)    |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module sha256_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [c_aw-1:0] next_ptr(input logic [c_aw-1:0] p);
    return (p == c_aw'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cw'(DEPTH));
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sha256_msg_padder : reads a message from word memory, streams it padded    |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int MAX_WORDS  = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] num_words,
  output logic        busy,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_word_idx,
  output logic        out_block_last
);

  localparam int c_cnt_w  = $clog2(MAX_WORDS + SHA256_BLOCK_WORDS + 3);
  localparam int c_fifo_w = $clog2(FIFO_DEPTH + 1);

  padder_state_t        r_state;
  logic [15:0]          r_base;
  logic [15:0]          r_num;
  logic [15:0]          r_total;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_inflight;
  logic [3:0]           r_word_idx;

  logic                 w_legal;
  logic                 w_xfer;
  logic                 w_issue;
  logic                 w_gen_push;
  logic                 w_fifo_push;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [c_fifo_w-1:0]  w_fifo_count;
  logic [15:0]          w_cnt_ext;
  logic [31:0]          w_gen_data;
  logic                 w_gen_tag;
  logic [32:0]          w_push_word;
  logic [32:0]          w_head_word;

  assign w_cnt_ext = 16'(r_cnt);
  assign w_legal   = (num_words != 16'd0) && (num_words <= 16'(MAX_WORDS));
  assign w_xfer    = out_valid && out_ready;

  // The read in flight already owns a FIFO slot; a pop this cycle frees one.
  assign w_issue    = (r_state == c_st_read) &&
                      ((int'(w_fifo_count) + int'(r_inflight)) < (FIFO_DEPTH + int'(w_xfer)));
  assign w_gen_push = (r_state == c_st_pad) && !r_inflight && (!w_fifo_full || w_xfer);

  always_comb begin
    w_gen_data = '0;
    w_gen_tag  = 1'b0;
    if (w_cnt_ext == r_num) w_gen_data = SHA256_PAD_MARKER;
    if (w_cnt_ext == r_total - 16'd1) begin
      w_gen_data = {11'd0, r_num, 5'd0};
      w_gen_tag  = 1'b1;
    end
  end

  assign w_fifo_push = r_inflight || w_gen_push;
  assign w_push_word = r_inflight ? {1'b0, mem_read_data} : {w_gen_tag, w_gen_data};

  sha256_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_fifo_push),
    .push_data (w_push_word),
    .pop       (w_xfer),
    .pop_data  (w_head_word),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign out_valid      = !w_fifo_empty;
  assign out_data       = w_head_word[31:0];
  assign out_block_last = out_valid && w_head_word[32];
  assign out_word_idx   = r_word_idx;
  assign busy           = (r_state != c_st_idle);
  assign done           = (r_state == c_st_finish);
  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign mem_write_data = '0;
  assign mem_addr       = r_base + w_cnt_ext;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= c_st_idle;
      r_base     <= '0;
      r_num      <= '0;
      r_total    <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_word_idx <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_xfer) r_word_idx <= r_word_idx + 1'b1;
      case (r_state)
        c_st_idle: begin
          if (start && w_legal) begin
            r_base     <= message_addr;
            r_num      <= num_words;
            r_total    <= pad_total_words(num_words);
            r_cnt      <= '0;
            r_word_idx <= '0;
            r_state    <= c_st_read;
          end
        end
        c_st_read: begin
          if (w_issue) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_ext == r_num - 16'd1) r_state <= c_st_pad;
          end
        end
        c_st_pad: begin
          if (w_gen_push) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_ext == r_total - 16'd1) r_state <= c_st_drain;
          end
        end
        c_st_drain: begin
          if (w_fifo_empty) r_state <= c_st_finish;
        end
        c_st_finish: r_state <= c_st_idle;
        default:     r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sha256_msg_padder : directed vector bench for sha256_msg_padder         |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_sha256_msg_padder;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] message_addr;
  logic [15:0] num_words;
  logic        busy;
  logic        done;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_word_idx;
  logic        out_block_last;

  typedef struct {
    int          n;
    logic [15:0] base;
    bit          rnd;
    bit          poke;
    int          exp_total;
    logic [31:0] exp_len;
    bit          legal;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  idx;
    logic        last;
  } rx_t;

  vec_t        vecs[11];
  rx_t         rcv[$];
  rx_t         prev_rx;
  logic [31:0] mem [65536];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          cyc_in_run = 0;
  int          first_valid = 0;
  int          last_xfer_cyc = 0;
  int          mem_bad = 0;
  bit          run_active = 1'b0;
  bit          prev_stall = 1'b0;

  sha256_msg_padder #(
    .MAX_WORDS  (64),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .message_addr   (message_addr),
    .num_words      (num_words),
    .busy           (busy),
    .done           (done),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_word_idx   (out_word_idx),
    .out_block_last (out_block_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with one cycle of read latency.
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int i, input int n, input logic [15:0] base,
                                             input int t);
    logic [15:0] a;
    a = base + 16'(i);
    if (i < n)      return mem[a];
    if (i == n)     return 32'h8000_0000;
    if (i == t - 1) return 32'(n * 32);
    return 32'd0;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},      32'(busy),           32'd0);
    chk({tag, "_done"},      32'(done),           32'd0);
    chk({tag, "_valid"},     32'(out_valid),      32'd0);
    chk({tag, "_last"},      32'(out_block_last), 32'd0);
    chk({tag, "_word_idx"},  32'(out_word_idx),   32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),       32'd0);
    chk({tag, "_out_data"},  out_data,            32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    int cyc;
    t = ((v.n + 3 + 15) / 16) * 16;
    rcv.delete();
    done_cnt      = 0;
    first_valid   = 0;
    last_xfer_cyc = 0;
    start         = 1'b1;
    message_addr  = v.base;
    num_words     = 16'(v.n);
    out_ready     = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    cyc_in_run = 0;
    run_active = 1'b1;
    if (!v.legal) begin
      repeat (6) begin @(posedge clk); #1; end
      chk($sformatf("n%0d_ignored_busy", v.n),  32'(busy),       32'd0);
      chk($sformatf("n%0d_ignored_done", v.n),  32'(done_cnt),   32'd0);
      chk($sformatf("n%0d_ignored_words", v.n), 32'(rcv.size()), 32'd0);
      run_active = 1'b0;
      return;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.poke) begin
        start        = (cyc == 6);
        message_addr = 16'h0100;
        num_words    = 16'd13;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    run_active = 1'b0;
    chk($sformatf("n%0d_done_pulses", v.n), 32'(done_cnt),   32'd1);
    chk($sformatf("n%0d_busy_after", v.n),  32'(busy),       32'd0);
    chk($sformatf("n%0d_word_count", v.n),  32'(rcv.size()), 32'(v.exp_total));
    chk($sformatf("n%0d_first_valid", v.n), 32'(first_valid), 32'd3);
    if (!v.rnd)
      chk($sformatf("n%0d_last_xfer_cycle", v.n), 32'(last_xfer_cyc), 32'(t + 2));
    if (rcv.size() > v.n)
      chk($sformatf("n%0d_marker", v.n), rcv[v.n].d, 32'h8000_0000);
    if (rcv.size() == v.exp_total)
      chk($sformatf("n%0d_len_word", v.n), rcv[v.exp_total-1].d, v.exp_len);
    for (int i = 0; i < rcv.size(); i++) begin
      chk($sformatf("n%0d_w%0d_data", v.n, i), rcv[i].d, model_word(i, v.n, v.base, t));
      chk($sformatf("n%0d_w%0d_idx", v.n, i), 32'(rcv[i].idx), 32'(i % 16));
      chk($sformatf("n%0d_w%0d_last", v.n, i), 32'(rcv[i].last), 32'(i == t - 1));
    end
  endtask

  task automatic reset_mid_run();
    int cyc;
    rcv.delete();
    done_cnt     = 0;
    start        = 1'b1;
    message_addr = 16'h0000;
    num_words    = 16'd20;
    out_ready    = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    cyc_in_run = 0;
    run_active = 1'b1;
    cyc = 0;
    while (rcv.size() < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("pre_reset_words", 32'(rcv.size()), 32'd5);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_all_zero("mid_reset");
    repeat (6) begin @(posedge clk); #1; end
    chk("words_after_reset", 32'(rcv.size()), 32'd5);
    chk("done_after_reset",  32'(done_cnt),   32'd0);
    run_active = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    //            n   base      rnd   poke  T   len word      legal
    vecs[0]  = '{20, 16'h0000, 1'b0, 1'b0, 32, 32'h0000_0280, 1'b1};
    vecs[1]  = '{13, 16'h0000, 1'b0, 1'b0, 16, 32'h0000_01A0, 1'b1};
    vecs[2]  = '{14, 16'h0000, 1'b0, 1'b0, 32, 32'h0000_01C0, 1'b1};
    vecs[3]  = '{20, 16'h0000, 1'b1, 1'b0, 32, 32'h0000_0280, 1'b1};
    vecs[4]  = '{20, 16'h0000, 1'b0, 1'b1, 32, 32'h0000_0280, 1'b1};
    vecs[5]  = '{1,  16'h0040, 1'b0, 1'b0, 16, 32'h0000_0020, 1'b1};
    vecs[6]  = '{64, 16'h0010, 1'b1, 1'b0, 80, 32'h0000_0800, 1'b1};
    vecs[7]  = '{61, 16'h0000, 1'b0, 1'b0, 64, 32'h0000_07A0, 1'b1};
    vecs[8]  = '{10, 16'hFFFA, 1'b0, 1'b0, 16, 32'h0000_0140, 1'b1};
    vecs[9]  = '{0,  16'h0000, 1'b0, 1'b0, 0,  32'h0000_0000, 1'b0};
    vecs[10] = '{65, 16'h0000, 1'b0, 1'b0, 0,  32'h0000_0000, 1'b0};

    w = 32'h0123_4765;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = w;
      w = {w[30:0], w[31]};
    end
    mem[19] = 32'd0;

    reset_n       = 1'b0;
    start         = 1'b0;
    message_addr  = 16'd0;
    num_words     = 16'd0;
    out_ready     = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (mem_we !== 1'b0 || mem_write_data !== 32'd0 || mem_clk !== 1'b0) mem_bad++;
        if (done === 1'b1) done_cnt++;
        cyc_in_run++;
        if (reset_n !== 1'b1) begin
          prev_stall = 1'b0;
        end else begin
          if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_rx.d || out_word_idx !== prev_rx.idx ||
                out_block_last !== prev_rx.last) begin
              errors++;
              $display("FAIL stall_hold actual valid=%b data=%h idx=%0d last=%b required valid=1 data=%h idx=%0d last=%b",
                       out_valid, out_data, out_word_idx, out_block_last,
                       prev_rx.d, prev_rx.idx, prev_rx.last);
            end
          end
          if (run_active && out_valid === 1'b1 && first_valid == 0) first_valid = cyc_in_run;
          if (run_active && out_valid === 1'b1 && out_ready === 1'b1) begin
            rcv.push_back('{out_data, out_word_idx, out_block_last});
            last_xfer_cyc = cyc_in_run;
          end
          prev_stall = (out_valid === 1'b1 && out_ready === 1'b0);
          prev_rx    = '{out_data, out_word_idx, out_block_last};
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        foreach (vecs[k]) run_vec(vecs[k]);
        reset_mid_run();
        run_vec(vecs[1]);
        chk("mem_write_side_idle", 32'(mem_bad), 32'd0);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
